// File: rtl/bram_pkg.sv
// Shared types and helpers for the dual-port byte-writable block RAM.
package bram_pkg;

   typedef enum logic [1:0] {
      RDW_READ_FIRST  = 2'd0,
      RDW_WRITE_FIRST = 2'd1,
      RDW_NO_CHANGE   = 2'd2
   } rdw_mode_e;

   localparam int unsigned MAX_BYTES = 16;
   localparam int unsigned MAX_W     = MAX_BYTES * 8;

   // Replace each byte of old_w whose sel bit is set with the matching byte of new_w.
   function automatic logic [MAX_W-1:0] merge_bytes(input logic [MAX_W-1:0]     old_w,
                                                    input logic [MAX_W-1:0]     new_w,
                                                    input logic [MAX_BYTES-1:0] sel);
      logic [MAX_W-1:0] res;
      res = old_w;
      for (int i = 0; i < int'(MAX_BYTES); i++) begin
         if (sel[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Per-port read return path: same-port read-during-write handling and optional output register.
module bram_rd_pipe
   import bram_pkg::*;
#(
   parameter int unsigned  DATA_L   = 4,
   parameter rdw_mode_e    RDW_MODE = RDW_READ_FIRST,
   parameter bit           OUT_REG  = 1'b0,
   localparam int unsigned DATA_W   = DATA_L * 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [DATA_L-1:0] sel,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] raw,
   output logic [DATA_W-1:0] data_r,
   output logic              valid
);

   logic              wr_c;
   logic              v1_d, v1_q;
   logic [DATA_W-1:0] d1_d, d1_q;

   // First stage: raw is the pre-edge word, so only write-first needs a merge.
   always_comb begin
      wr_c = |sel;
      v1_d = en && !((RDW_MODE == RDW_NO_CHANGE) && wr_c);
      d1_d = d1_q;
      if (v1_d) begin
         if (RDW_MODE == RDW_WRITE_FIRST) begin
            d1_d = DATA_W'(merge_bytes(MAX_W'(raw), MAX_W'(wdata), MAX_BYTES'(sel)));
         end else begin
            d1_d = raw;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         d1_q <= '0;
      end else begin
         v1_q <= v1_d;
         d1_q <= d1_d;
      end
   end

   if (OUT_REG) begin : g_out_reg
      logic              v2_d, v2_q;
      logic [DATA_W-1:0] d2_d, d2_q;

      always_comb begin
         v2_d = v1_q;
         d2_d = v1_q ? d1_q : d2_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v2_q <= 1'b0;
            d2_q <= '0;
         end else begin
            v2_q <= v2_d;
            d2_q <= d2_d;
         end
      end

      assign data_r = d2_q;
      assign valid  = v2_q;
   end else begin : g_no_out_reg
      assign data_r = d1_q;
      assign valid  = v1_q;
   end

endmodule

// File: rtl/dual_bram.sv
// True dual-port byte-writable block RAM with per-port read valid and write-collision flag.
module dual_bram
   import bram_pkg::*;
#(
   parameter int unsigned  ADDR_W   = 14,
   parameter int unsigned  SIZE     = 1 << ADDR_W,
   parameter int unsigned  DATA_L   = 4,
   parameter rdw_mode_e    RDW_MODE = RDW_READ_FIRST,
   parameter bit           OUT_REG  = 1'b0,
   localparam int unsigned DATA_W   = DATA_L * 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data_w,
   input  logic [DATA_L-1:0] a_sel,
   input  logic              a_en,
   output logic [DATA_W-1:0] a_data_r,
   output logic              a_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data_w,
   input  logic [DATA_L-1:0] b_sel,
   input  logic              b_en,
   output logic [DATA_W-1:0] b_data_r,
   output logic              b_valid,
   output logic              collision
);

   logic [DATA_W-1:0] mem_q [SIZE];
   logic              a_ok, b_ok;
   logic [DATA_W-1:0] a_raw, b_raw;
   logic              collision_d, collision_q;

   if (DATA_L > MAX_BYTES) begin : g_bad_width
      $error("dual_bram: DATA_L exceeds bram_pkg::MAX_BYTES");
   end

   // Addresses beyond SIZE only exist when SIZE is not a full power of two.
   if (SIZE == (1 << ADDR_W)) begin : g_full
      assign a_ok = 1'b1;
      assign b_ok = 1'b1;
   end else begin : g_part
      assign a_ok = 32'(a_addr) < SIZE;
      assign b_ok = 32'(b_addr) < SIZE;
   end

   // Array read before this edge's writes land: old data for both ports.
   assign a_raw = a_ok ? mem_q[a_addr] : '0;
   assign b_raw = b_ok ? mem_q[b_addr] : '0;

   // Port A is applied last so it owns bytes both ports write.
   always_ff @(posedge clk) begin : p_mem_wr
      for (int i = 0; i < int'(DATA_L); i++) begin
         if (b_en && b_ok && b_sel[i]) mem_q[b_addr][i*8 +: 8] <= b_data_w[i*8 +: 8];
      end
      for (int i = 0; i < int'(DATA_L); i++) begin
         if (a_en && a_ok && a_sel[i]) mem_q[a_addr][i*8 +: 8] <= a_data_w[i*8 +: 8];
      end
   end

   always_comb begin
      collision_d = a_en && b_en && (a_addr == b_addr) && (|(a_sel & b_sel));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) collision_q <= 1'b0;
      else        collision_q <= collision_d;
   end

   assign collision = collision_q;

   bram_rd_pipe #(
      .DATA_L  (DATA_L),
      .RDW_MODE(RDW_MODE),
      .OUT_REG (OUT_REG)
   ) u_rd_a (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (a_en),
      .sel   (a_sel),
      .wdata (a_data_w),
      .raw   (a_raw),
      .data_r(a_data_r),
      .valid (a_valid)
   );

   bram_rd_pipe #(
      .DATA_L  (DATA_L),
      .RDW_MODE(RDW_MODE),
      .OUT_REG (OUT_REG)
   ) u_rd_b (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (b_en),
      .sel   (b_sel),
      .wdata (b_data_w),
      .raw   (b_raw),
      .data_r(b_data_r),
      .valid (b_valid)
   );

   a_addr_range: assert property (@(posedge clk) disable iff (!rst_n) a_en |-> a_ok)
      else $error("dual_bram: port A address beyond SIZE");
   b_addr_range: assert property (@(posedge clk) disable iff (!rst_n) b_en |-> b_ok)
      else $error("dual_bram: port B address beyond SIZE");

endmodule

// File: tb/tb_dual_bram.sv
// Scoreboard bench for dual_bram: three configurations driven in lockstep against one memory model.
`timescale 1ns/1ps
module tb_dual_bram;
   import bram_pkg::*;

   localparam int unsigned ADDR_W = 14;
   localparam int unsigned DATA_L = 4;
   localparam int unsigned DATA_W = DATA_L * 8;
   localparam int          NDUT   = 3;

   typedef struct {
      logic [DATA_W-1:0] data;
      int                cyc;
      bit                chk;
   } exp_t;

   typedef struct {
      logic              en;
      logic [ADDR_W-1:0] addr;
      logic [DATA_L-1:0] sel;
      logic [DATA_W-1:0] data;
   } req_t;

   function automatic rdw_mode_e mode_of(input int g);
      return (g == 0) ? RDW_READ_FIRST : (g == 1) ? RDW_WRITE_FIRST : RDW_NO_CHANGE;
   endfunction

   function automatic int lat_of(input int g);
      return (g == 1) ? 2 : 1;
   endfunction

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
   logic [DATA_W-1:0] a_data_w = '0, b_data_w = '0;
   logic [DATA_L-1:0] a_sel = '0, b_sel = '0;
   logic              a_en = 1'b0, b_en = 1'b0;

   logic [DATA_W-1:0] a_dr [NDUT];
   logic [DATA_W-1:0] b_dr [NDUT];
   logic              a_v  [NDUT];
   logic              b_v  [NDUT];
   logic              col  [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      dual_bram #(
         .ADDR_W  (ADDR_W),
         .SIZE    (1 << ADDR_W),
         .DATA_L  (DATA_L),
         .RDW_MODE(mode_of(g)),
         .OUT_REG (lat_of(g) == 2)
      ) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .a_addr   (a_addr),
         .a_data_w (a_data_w),
         .a_sel    (a_sel),
         .a_en     (a_en),
         .a_data_r (a_dr[g]),
         .a_valid  (a_v[g]),
         .b_addr   (b_addr),
         .b_data_w (b_data_w),
         .b_sel    (b_sel),
         .b_en     (b_en),
         .b_data_r (b_dr[g]),
         .b_valid  (b_v[g]),
         .collision(col[g])
      );
   end

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   logic [DATA_W-1:0] mem_m [1 << ADDR_W];
   bit                known [1 << ADDR_W];
   exp_t              q [2][NDUT][$];
   bit                exp_col [int];
   logic [DATA_W-1:0] last_d [2][NDUT];

   task automatic chk(input string name, input int g, input logic [DATA_W-1:0] act,
                      input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s dut%0d cyc %0d: got %h expected %h", name, g, cyc, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] mrg(input logic [DATA_W-1:0] o, input logic [DATA_W-1:0] n,
                                             input logic [DATA_L-1:0] s);
      logic [DATA_W-1:0] r;
      r = o;
      for (int i = 0; i < int'(DATA_L); i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
      return r;
   endfunction

   function automatic req_t rq(input logic en, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_L-1:0] sel, input logic [DATA_W-1:0] data);
      req_t r;
      r.en = en; r.addr = addr; r.sel = sel; r.data = data;
      return r;
   endfunction

   function automatic logic [ADDR_W-1:0] addr_of(input int r);
      return (r < 16) ? ADDR_W'(r) : ADDR_W'(r + 16364);
   endfunction

   function automatic req_t rand_req();
      logic [DATA_L-1:0] s;
      s = ($urandom_range(0, 2) == 0) ? '0 : DATA_L'($urandom);
      return rq($urandom_range(0, 3) != 0, addr_of(int'($urandom_range(0, 19))), s, $urandom);
   endfunction

   // Reference: expected read per configuration, then apply writes with port A winning overlaps.
   function automatic void model(input req_t a, input req_t b);
      int                n;
      req_t              r [2];
      logic [DATA_W-1:0] old_w [2];
      exp_t              e;
      n = cyc + 1;
      r[0] = a; r[1] = b;
      for (int p = 0; p < 2; p++) old_w[p] = mem_m[r[p].addr];
      for (int p = 0; p < 2; p++) begin
         if (!r[p].en) continue;
         for (int g = 0; g < NDUT; g++) begin
            if (r[p].sel != 0 && mode_of(g) == RDW_NO_CHANGE) continue;
            e.cyc  = n + lat_of(g) - 1;
            e.data = (r[p].sel != 0 && mode_of(g) == RDW_WRITE_FIRST)
                     ? mrg(old_w[p], r[p].data, r[p].sel) : old_w[p];
            e.chk  = known[r[p].addr] || (mode_of(g) == RDW_WRITE_FIRST && r[p].sel == '1);
            q[p][g].push_back(e);
         end
      end
      if (a.en && b.en && a.addr == b.addr && (a.sel & b.sel) != 0) exp_col[n] = 1'b1;
      for (int p = 1; p >= 0; p--) begin
         if (r[p].en) begin
            mem_m[r[p].addr] = mrg(mem_m[r[p].addr], r[p].data, r[p].sel);
            if (r[p].sel == '1) known[r[p].addr] = 1'b1;
         end
      end
   endfunction

   task automatic issue(input req_t a, input req_t b);
      @(negedge clk);
      a_en = a.en; a_addr = a.addr; a_sel = a.sel; a_data_w = a.data;
      b_en = b.en; b_addr = b.addr; b_sel = b.sel; b_data_w = b.data;
      model(a, b);
   endtask

   task automatic check_reset_outputs();
      for (int g = 0; g < NDUT; g++) begin
         chk("rst a_data_r", g, a_dr[g], '0);
         chk("rst b_data_r", g, b_dr[g], '0);
         chk("rst a_valid", g, DATA_W'(a_v[g]), '0);
         chk("rst b_valid", g, DATA_W'(b_v[g]), '0);
         chk("rst collision", g, DATA_W'(col[g]), '0);
      end
   endtask

   task automatic do_reset(input int hold);
      @(negedge clk);
      a_en = 1'b0; b_en = 1'b0;
      rst_n = 1'b0;
      for (int p = 0; p < 2; p++) for (int g = 0; g < NDUT; g++) begin
         q[p][g].delete();
         last_d[p][g] = '0;
      end
      exp_col.delete();
      #1;
      check_reset_outputs();
      repeat (hold) @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic bit all_empty();
      for (int p = 0; p < 2; p++) for (int g = 0; g < NDUT; g++) if (q[p][g].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // Monitor: pop on every valid, check timing/data, missed valids, hold and collision.
   always @(negedge clk) begin : p_mon
      exp_t              e;
      logic              v;
      logic [DATA_W-1:0] d;
      if (rst_n) begin
         for (int p = 0; p < 2; p++) begin
            for (int g = 0; g < NDUT; g++) begin
               v = (p == 0) ? a_v[g] : b_v[g];
               d = (p == 0) ? a_dr[g] : b_dr[g];
               if (v) begin
                  if (q[p][g].size() == 0) begin
                     chk(p == 0 ? "a unexpected valid" : "b unexpected valid", g, 1, 0);
                  end else begin
                     e = q[p][g].pop_front();
                     chk(p == 0 ? "a valid cycle" : "b valid cycle", g, DATA_W'(cyc), DATA_W'(e.cyc));
                     if (e.chk) chk(p == 0 ? "a read data" : "b read data", g, d, e.data);
                  end
                  last_d[p][g] = d;
               end else begin
                  chk(p == 0 ? "a hold" : "b hold", g, d, last_d[p][g]);
                  if (q[p][g].size() != 0 && q[p][g][0].cyc <= cyc) begin
                     e = q[p][g].pop_front();
                     chk(p == 0 ? "a missing valid" : "b missing valid", g, 0, 1);
                  end
               end
            end
         end
         for (int g = 0; g < NDUT; g++) chk("collision", g, DATA_W'(col[g]), DATA_W'(exp_col.exists(cyc)));
      end
   end

   initial begin : p_watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : p_stim
      req_t idle;
      idle = rq(1'b0, '0, '0, '0);
      for (int p = 0; p < 2; p++) for (int g = 0; g < NDUT; g++) last_d[p][g] = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;

      for (int r = 0; r < 20; r += 2)
         issue(rq(1, addr_of(r), '1, $urandom), rq(1, addr_of(r + 1), '1, $urandom));

      // Basic write then read.
      issue(rq(1, 14'd5, 4'hF, 32'hDEADBEEF), idle);
      issue(rq(1, 14'd5, 4'h0, '0), idle);
      issue(idle, idle);
      // Byte enables.
      issue(rq(1, 14'd7, 4'hF, 32'h11223344), idle);
      issue(rq(1, 14'd7, 4'b0101, 32'hAABBCCDD), idle);
      issue(rq(1, 14'd7, 4'h0, '0), idle);
      // Same-port read-during-write.
      issue(rq(1, 14'd3, 4'hF, 32'h0), idle);
      issue(rq(1, 14'd3, 4'hF, 32'hFFFFFFFF), idle);
      issue(idle, idle);
      issue(rq(1, 14'd3, 4'h0, '0), idle);
      // Cross-port read of a location being written.
      issue(idle, rq(1, 14'd9, 4'hF, 32'hCAFEF00D));
      issue(rq(1, 14'd9, 4'hF, 32'h12345678), rq(1, 14'd9, 4'h0, '0));
      issue(idle, rq(1, 14'd9, 4'h0, '0));
      // Overlapping and disjoint same-address writes.
      issue(rq(1, 14'd2, 4'hF, 32'h0), idle);
      issue(rq(1, 14'd2, 4'b0011, 32'hAAAAAAAA), rq(1, 14'd2, 4'b0110, 32'hBBBBBBBB));
      issue(rq(1, 14'd2, 4'h0, '0), idle);
      issue(rq(1, 14'd2, 4'hF, 32'h0), idle);
      issue(rq(1, 14'd2, 4'b0011, 32'hAAAAAAAA), rq(1, 14'd2, 4'b1100, 32'hBBBBBBBB));
      issue(rq(1, 14'd2, 4'h0, '0), rq(1, 14'd2, 4'h0, '0));
      // Reset with reads in flight, then read back.
      issue(rq(1, 14'd5, 4'h0, '0), rq(1, 14'd7, 4'h0, '0));
      issue(rq(1, 14'd9, 4'h0, '0), rq(1, 14'd2, 4'h0, '0));
      issue(rq(1, 14'd3, 4'h0, '0), rq(1, 14'd5, 4'h0, '0));
      do_reset(2);
      issue(idle, idle);
      issue(rq(1, 14'd5, 4'h0, '0), rq(1, 14'd9, 4'h0, '0));
      issue(rq(1, 14'd7, 4'h0, '0), rq(1, 14'd2, 4'h0, '0));
      issue(idle, idle);

      for (int k = 0; k < 600; k++) issue(rand_req(), rand_req());
      issue(idle, idle);

      for (int k = 0; k < 10 && !all_empty(); k++) @(negedge clk);
      @(negedge clk);
      chk("drain", 0, DATA_W'(all_empty()), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
